// File: rtl/masked_mem_bank.sv
// Bit-masked memory bank with a registered, write-first read port (1-cycle latency).
// A DEPTH-cycle INIT sweep zeroes every word after reset or init_req; accesses are dropped while it runs.
module masked_mem_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy
);

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_e;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_in_range, rd_in_range;
  logic                wr_fire, rd_fire;
  logic [DATA_W-1:0]   wr_old, wr_merged, rd_word;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Output / access-qualification logic; init_req pre-empts any access in the same cycle
  always_comb begin
    init_busy = (state_q == ST_INIT);
    wr_fire   = (state_q == ST_IDLE) && !init_req && wr_en && wr_in_range;
    rd_fire   = (state_q == ST_IDLE) && !init_req && rd_en;
  end

  always_comb begin
    wr_old    = wr_in_range ? mem_q[wr_addr] : '0;
    wr_merged = (wr_old & ~wr_mask) | (wr_data & wr_mask);
    if (!rd_in_range)
      rd_word = '0;
    else if (wr_fire && (wr_addr == rd_addr))
      rd_word = wr_merged;
    else
      rd_word = mem_q[rd_addr];
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is deliberately left out of reset; the INIT sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (init_busy)
      mem_q[clr_cnt_q] <= '0;
    else if (wr_fire)
      mem_q[wr_addr] <= wr_merged;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
